pipe_depth_ctrl: RTL and testbench
==================================

Name: pipe_depth_ctrl

Overview:
Slow-control sequencer for the pipeline start FSM. It holds the pipeline depth (PDEPTH) stable and accepts depth updates from the configuration interface. On each accepted update or forced restart it issues a RESTART pulse, waits for the pipe's read-enable to drop and return, and reports ready, timeout and error status. It sits between the JTAG/config register block and the pipe start FSM.

Parameters:
DEFAULT_DEPTH, 9'd100, PDEPTH value loaded at reset
MIN_DEPTH, 9'd4, smallest accepted depth (inclusive)
MAX_DEPTH, 9'd500, largest accepted depth (inclusive)
TIMEOUT, 10'd1000, cycles allowed from the RESTART pulse to pipe running; must be > MAX_DEPTH+40

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
CFG_WR  in  1  one-cycle depth write strobe
CFG_DEPTH  in  9  requested depth, sampled with CFG_WR
FORCE_RESTART  in  1  one-cycle restart request without a depth change
CLR_ERR  in  1  clears the sticky error flags
PIPE_RE  in  1  RE output of the pipe start FSM (1 = pipe running)
PDEPTH  out  9  depth to the pipe start FSM
RESTART  out  1  one-cycle restart pulse to the pipe start FSM
CFG_ACK  out  1  one-cycle pulse: write accepted
CFG_NAK  out  1  one-cycle pulse: write rejected
BUSY  out  1  restart sequence in progress
READY  out  1  pipe confirmed running with the current PDEPTH
DEPTH_ERR  out  1  sticky: out-of-range write seen
TIMEOUT_ERR  out  1  sticky: restart did not complete in time
RESTART_CNT  out  8  completed restarts, saturating at 255

Behaviour:
- All outputs registered except BUSY, which is decoded from state.
- States: IDLE, RESTART, WAIT_DROP, WAIT_RUN.
- Reset values:
  - state = WAIT_RUN (the pipe FSM starts itself on the same reset).
  - PDEPTH = DEFAULT_DEPTH.
  - RESTART, CFG_ACK, CFG_NAK, READY, DEPTH_ERR, TIMEOUT_ERR = 0; RESTART_CNT = 0; timer = 0.
  - BUSY = 1 during and after reset until the pipe is first seen running.
- BUSY = 1 in RESTART, WAIT_DROP and WAIT_RUN; 0 in IDLE.
- IDLE:
  - CFG_WR with MIN_DEPTH <= CFG_DEPTH <= MAX_DEPTH at edge n: PDEPTH <= CFG_DEPTH, CFG_ACK=1 and READY=0 in cycle n+1, state -> RESTART.
  - CFG_WR out of range: CFG_NAK=1 in n+1, DEPTH_ERR set, PDEPTH unchanged, stay IDLE.
  - FORCE_RESTART alone: READY=0, state -> RESTART.
  - CFG_WR valid together with FORCE_RESTART: handle as a write; exactly one restart.
  - CFG_WR invalid together with FORCE_RESTART: NAK, and the restart proceeds.
  - PIPE_RE low while READY=1 (unexpected loss): READY=0, state -> WAIT_RUN, timer cleared.
- RESTART state: RESTART=1 in the following cycle for exactly 1 cycle; timer cleared; state -> WAIT_DROP.
- WAIT_DROP: wait for PIPE_RE=0, then -> WAIT_RUN.
- WAIT_RUN: PIPE_RE=1 -> READY=1, RESTART_CNT+1 (saturating at 255), state -> IDLE. The post-reset entry does not count.
- Timer:
  - 10-bit; increments every cycle in WAIT_DROP/WAIT_RUN; never wraps.
  - Reaching TIMEOUT in either state: TIMEOUT_ERR set, READY=0, state -> IDLE.
- CFG_WR while BUSY: CFG_NAK pulse, ignored, DEPTH_ERR unchanged. FORCE_RESTART while BUSY: ignored.
- PDEPTH changes only on an accepted write, and therefore only in IDLE.
- CLR_ERR clears both sticky flags next edge. An error set in the same cycle as CLR_ERR wins.
- RST mid-sequence: all registers return to reset values immediately (async); no RESTART pulse is emitted.

Test Plan:
1. Bench instantiates the pipe start FSM driven by PDEPTH/RESTART. Release reset -> BUSY=1, READY=0 until the FSM RE rises (~135 cycles at depth 100); then READY=1, BUSY=0, RESTART_CNT=0.
2. From READY, CFG_WR with CFG_DEPTH=200 -> CFG_ACK next cycle, PDEPTH=200, one RESTART pulse, PIPE_RE drops then rises; READY=1 and RESTART_CNT=1.
3. CFG_WR with CFG_DEPTH=2, then CFG_DEPTH=511 -> CFG_NAK each time, DEPTH_ERR=1, PDEPTH unchanged, no RESTART. CLR_ERR -> DEPTH_ERR=0.
4. CFG_WR=300 during WAIT_RUN -> CFG_NAK, PDEPTH unchanged. Simultaneous CFG_WR=50 with FORCE_RESTART in IDLE -> one RESTART pulse, PDEPTH=50, count +1.
5. PIPE_RE held at 1 after a restart -> TIMEOUT_ERR=1 after TIMEOUT cycles, state IDLE, READY=0. PIPE_RE held at 0 -> same result from WAIT_RUN.
6. Assert RST during WAIT_DROP -> PDEPTH=100, counters/flags 0, no RESTART pulse. Also: force PIPE_RE low for 1 cycle while READY -> READY=0 and recovery when RE returns.

Source files
------------

// File: rtl/pipe_depth_ctrl_if.sv
// Config/status bundle between the register block,
// the depth sequencer and the pipe start FSM.
interface pipe_depth_ctrl_if;
  logic       CFG_WR;
  logic [8:0] CFG_DEPTH;
  logic       FORCE_RESTART;
  logic       CLR_ERR;
  logic       PIPE_RE;
  logic [8:0] PDEPTH;
  logic       RESTART;
  logic       CFG_ACK;
  logic       CFG_NAK;
  logic       BUSY;
  logic       READY;
  logic       DEPTH_ERR;
  logic       TIMEOUT_ERR;
  logic [7:0] RESTART_CNT;

  modport master (
    output CFG_WR, CFG_DEPTH, FORCE_RESTART,
    output CLR_ERR, PIPE_RE,
    input  PDEPTH, RESTART, CFG_ACK, CFG_NAK,
    input  BUSY, READY, DEPTH_ERR, TIMEOUT_ERR,
    input  RESTART_CNT
  );

  modport slave (
    input  CFG_WR, CFG_DEPTH, FORCE_RESTART,
    input  CLR_ERR, PIPE_RE,
    output PDEPTH, RESTART, CFG_ACK, CFG_NAK,
    output BUSY, READY, DEPTH_ERR, TIMEOUT_ERR,
    output RESTART_CNT
  );
endinterface

// File: rtl/pipe_depth_ctrl.sv
// Pipeline depth sequencer: accepts depth writes,
// pulses RESTART and tracks pipe RE back to running.
module pipe_depth_ctrl #(
  parameter logic [8:0] DEFAULT_DEPTH = 9'd100,
  parameter logic [8:0] MIN_DEPTH     = 9'd4,
  parameter logic [8:0] MAX_DEPTH     = 9'd500,
  parameter logic [9:0] TIMEOUT       = 10'd1000
) (
  input  logic               CLK,
  input  logic               RST,
  pipe_depth_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESTART,
    ST_WAIT_DROP,
    ST_WAIT_RUN
  } state_t;

  state_t     r_state, w_state;
  logic [8:0] r_pdepth, w_pdepth;
  logic       r_restart, w_restart;
  logic       r_ack, w_ack;
  logic       r_nak, w_nak;
  logic       r_ready, w_ready;
  logic       r_derr, w_derr;
  logic       r_terr, w_terr;
  logic [7:0] r_cnt, w_cnt;
  logic [9:0] r_timer, w_timer;
  logic       r_pend, w_pend;
  logic       w_in_rng;
  logic       w_tmo;

  assign w_in_rng = (bus.CFG_DEPTH >= MIN_DEPTH) &&
                    (bus.CFG_DEPTH <= MAX_DEPTH);
  assign w_tmo    = (r_timer >= TIMEOUT - 10'd1);

  always_comb begin
    w_state   = r_state;
    w_pdepth  = r_pdepth;
    w_restart = 1'b0;
    w_ack     = 1'b0;
    w_nak     = 1'b0;
    w_ready   = r_ready;
    w_derr    = r_derr & ~bus.CLR_ERR;
    w_terr    = r_terr & ~bus.CLR_ERR;
    w_cnt     = r_cnt;
    w_timer   = r_timer;
    w_pend    = r_pend;
    if (r_state != ST_IDLE && bus.CFG_WR)
      w_nak = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.CFG_WR && w_in_rng) begin
          w_pdepth = bus.CFG_DEPTH;
          w_ack    = 1'b1;
          w_ready  = 1'b0;
          w_state  = ST_RESTART;
        end else if (bus.CFG_WR) begin
          w_nak  = 1'b1;
          w_derr = 1'b1;
          if (bus.FORCE_RESTART) begin
            w_ready = 1'b0;
            w_state = ST_RESTART;
          end
        end else if (bus.FORCE_RESTART) begin
          w_ready = 1'b0;
          w_state = ST_RESTART;
        end else if (r_ready && !bus.PIPE_RE) begin
          w_ready = 1'b0;
          w_timer = '0;
          w_state = ST_WAIT_RUN;
        end
      end
      ST_RESTART: begin
        w_restart = 1'b1;
        w_timer   = '0;
        w_pend    = 1'b1;
        w_state   = ST_WAIT_DROP;
      end
      ST_WAIT_DROP: begin
        w_timer = (r_timer == 10'h3FF) ? r_timer
                                       : r_timer + 10'd1;
        if (!bus.PIPE_RE) begin
          w_state = ST_WAIT_RUN;
        end else if (w_tmo) begin
          w_terr  = 1'b1;
          w_ready = 1'b0;
          w_pend  = 1'b0;
          w_state = ST_IDLE;
        end
      end
      ST_WAIT_RUN: begin
        w_timer = (r_timer == 10'h3FF) ? r_timer
                                       : r_timer + 10'd1;
        if (bus.PIPE_RE) begin
          w_ready = 1'b1;
          w_pend  = 1'b0;
          // post-reset and RE-loss recoveries are not restarts
          if (r_pend && r_cnt != 8'hFF)
            w_cnt = r_cnt + 8'd1;
          w_state = ST_IDLE;
        end else if (w_tmo) begin
          w_terr  = 1'b1;
          w_ready = 1'b0;
          w_pend  = 1'b0;
          w_state = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_WAIT_RUN;
      r_pdepth  <= DEFAULT_DEPTH;
      r_restart <= 1'b0;
      r_ack     <= 1'b0;
      r_nak     <= 1'b0;
      r_ready   <= 1'b0;
      r_derr    <= 1'b0;
      r_terr    <= 1'b0;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pdepth  <= w_pdepth;
      r_restart <= w_restart;
      r_ack     <= w_ack;
      r_nak     <= w_nak;
      r_ready   <= w_ready;
      r_derr    <= w_derr;
      r_terr    <= w_terr;
      r_cnt     <= w_cnt;
      r_timer   <= w_timer;
      r_pend    <= w_pend;
    end
  end

  assign bus.PDEPTH      = r_pdepth;
  assign bus.RESTART     = r_restart;
  assign bus.CFG_ACK     = r_ack;
  assign bus.CFG_NAK     = r_nak;
  assign bus.BUSY        = (r_state != ST_IDLE);
  assign bus.READY       = r_ready;
  assign bus.DEPTH_ERR   = r_derr;
  assign bus.TIMEOUT_ERR = r_terr;
  assign bus.RESTART_CNT = r_cnt;

endmodule

// File: tb/tb_pipe_depth_ctrl.sv
// Directed bench for pipe_depth_ctrl with a simple
// pipe start FSM model (RE rises PDEPTH+35 cycles in).
module tb_pipe_depth_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pipe_depth_ctrl_if bus ();

  pipe_depth_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  int mode = 0;

  logic       m_re;
  logic [9:0] m_cnt;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_re  <= 1'b0;
      m_cnt <= '0;
    end else if (bus.RESTART) begin
      m_re  <= 1'b0;
      m_cnt <= '0;
    end else if (!m_re) begin
      if (m_cnt == {1'b0, bus.PDEPTH} + 10'd34)
        m_re <= 1'b1;
      else
        m_cnt <= m_cnt + 10'd1;
    end
  end

  always @(posedge CLK)
    if (bus.RESTART === 1'b1) n_pulse <= n_pulse + 1;

  assign bus.PIPE_RE = (mode == 0) ? m_re :
                       (mode == 1) ? 1'b1 : 1'b0;

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if (bus.READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_wr(input logic [8:0] d,
                       input logic f);
    @(negedge CLK);
    bus.CFG_WR = 1'b1;
    bus.CFG_DEPTH = d;
    bus.FORCE_RESTART = f;
    @(negedge CLK);
    bus.CFG_WR = 1'b0;
    bus.FORCE_RESTART = 1'b0;
  endtask

  task automatic do_force();
    @(negedge CLK);
    bus.FORCE_RESTART = 1'b1;
    @(negedge CLK);
    bus.FORCE_RESTART = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (bus.BUSY !== 1'b1 || bus.READY !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy: busy=%b ready=%b want 1/0",
               bus.BUSY, bus.READY);
    end
    n_cmp++;
    if (bus.PDEPTH !== 9'd100 || bus.RESTART_CNT !== 8'd0
        || bus.DEPTH_ERR !== 1'b0
        || bus.TIMEOUT_ERR !== 1'b0
        || bus.RESTART !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_vals: pd=%0d cnt=%0d de=%b te=%b",
               bus.PDEPTH, bus.RESTART_CNT,
               bus.DEPTH_ERR, bus.TIMEOUT_ERR);
    end
    wait_ready(ok);
    n_cmp++;
    if (!ok || bus.BUSY !== 1'b0
        || bus.RESTART_CNT !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_run: ok=%b busy=%b cnt=%0d want 1/0/0",
               ok, bus.BUSY, bus.RESTART_CNT);
    end
  endtask

  task automatic test_write();
    bit ok;
    int p0;
    p0 = n_pulse;
    do_wr(9'd200, 1'b0);
    n_cmp++;
    if (bus.CFG_ACK !== 1'b1 || bus.PDEPTH !== 9'd200
        || bus.READY !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_ack: ack=%b pd=%0d rdy=%b want 1/200/0",
               bus.CFG_ACK, bus.PDEPTH, bus.READY);
    end
    wait_ready(ok);
    n_cmp++;
    if (!ok || n_pulse - p0 != 1
        || bus.RESTART_CNT !== 8'd1) begin
      n_bad++;
      $display("FAIL wr_done: ok=%b pulses=%0d cnt=%0d want 1/1/1",
               ok, n_pulse - p0, bus.RESTART_CNT);
    end
  endtask

  task automatic test_range();
    int p0;
    p0 = n_pulse;
    do_wr(9'd2, 1'b0);
    n_cmp++;
    if (bus.CFG_NAK !== 1'b1 || bus.DEPTH_ERR !== 1'b1
        || bus.PDEPTH !== 9'd200 || bus.BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL nak_lo: nak=%b de=%b pd=%0d busy=%b",
               bus.CFG_NAK, bus.DEPTH_ERR,
               bus.PDEPTH, bus.BUSY);
    end
    do_wr(9'd511, 1'b0);
    n_cmp++;
    if (bus.CFG_NAK !== 1'b1 || bus.DEPTH_ERR !== 1'b1
        || bus.PDEPTH !== 9'd200) begin
      n_bad++;
      $display("FAIL nak_hi: nak=%b de=%b pd=%0d want 1/1/200",
               bus.CFG_NAK, bus.DEPTH_ERR, bus.PDEPTH);
    end
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (n_pulse != p0 || bus.READY !== 1'b1) begin
      n_bad++;
      $display("FAIL nak_norst: pulses=%0d rdy=%b want 0/1",
               n_pulse - p0, bus.READY);
    end
    bus.CLR_ERR = 1'b1;
    @(negedge CLK);
    bus.CLR_ERR = 1'b0;
    n_cmp++;
    if (bus.DEPTH_ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_err: de=%b want 0", bus.DEPTH_ERR);
    end
  endtask

  task automatic test_busy_and_combo();
    bit ok;
    int p0;
    do_force();
    repeat (10) @(negedge CLK);
    do_wr(9'd300, 1'b0);
    n_cmp++;
    if (bus.CFG_NAK !== 1'b1 || bus.PDEPTH !== 9'd200
        || bus.DEPTH_ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_nak: nak=%b pd=%0d de=%b busy=%b",
               bus.CFG_NAK, bus.PDEPTH,
               bus.DEPTH_ERR, bus.BUSY);
    end
    wait_ready(ok);
    n_cmp++;
    if (!ok || bus.RESTART_CNT !== 8'd2) begin
      n_bad++;
      $display("FAIL force_done: ok=%b cnt=%0d want 1/2",
               ok, bus.RESTART_CNT);
    end
    p0 = n_pulse;
    do_wr(9'd50, 1'b1);
    n_cmp++;
    if (bus.CFG_ACK !== 1'b1 || bus.PDEPTH !== 9'd50) begin
      n_bad++;
      $display("FAIL combo_ack: ack=%b pd=%0d want 1/50",
               bus.CFG_ACK, bus.PDEPTH);
    end
    wait_ready(ok);
    n_cmp++;
    if (!ok || n_pulse - p0 != 1
        || bus.RESTART_CNT !== 8'd3) begin
      n_bad++;
      $display("FAIL combo_done: ok=%b pulses=%0d cnt=%0d want 1/1/3",
               ok, n_pulse - p0, bus.RESTART_CNT);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    for (int m = 1; m <= 2; m++) begin
      mode = m;
      do_force();
      n = 0;
      while (bus.TIMEOUT_ERR !== 1'b1 && n < 1500) begin
        @(negedge CLK);
        n++;
      end
      n_cmp++;
      if (n < 1000 || n > 1003 || bus.READY !== 1'b0
          || bus.BUSY !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_m%0d: cyc=%0d rdy=%b busy=%b want 1001/0/0",
                 m, n, bus.READY, bus.BUSY);
      end
      n_cmp++;
      if (bus.RESTART_CNT !== 8'd3) begin
        n_bad++;
        $display("FAIL tmo_cnt%0d: cnt=%0d want 3",
                 m, bus.RESTART_CNT);
      end
      bus.CLR_ERR = 1'b1;
      @(negedge CLK);
      bus.CLR_ERR = 1'b0;
      n_cmp++;
      if (bus.TIMEOUT_ERR !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_clr%0d: te=%b want 0",
                 m, bus.TIMEOUT_ERR);
      end
    end
    mode = 0;
    do_force();
    wait_ready(ok);
    n_cmp++;
    if (!ok || bus.RESTART_CNT !== 8'd4) begin
      n_bad++;
      $display("FAIL tmo_recover: ok=%b cnt=%0d want 1/4",
               ok, bus.RESTART_CNT);
    end
  endtask

  task automatic test_re_loss();
    @(negedge CLK);
    mode = 2;
    @(negedge CLK);
    mode = 0;
    n_cmp++;
    if (bus.READY !== 1'b0 || bus.BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL loss: rdy=%b busy=%b want 0/1",
               bus.READY, bus.BUSY);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.READY !== 1'b1 || bus.RESTART_CNT !== 8'd4) begin
      n_bad++;
      $display("FAIL loss_back: rdy=%b cnt=%0d want 1/4",
               bus.READY, bus.RESTART_CNT);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int p0;
    mode = 1;
    do_force();
    repeat (5) @(negedge CLK);
    p0 = n_pulse;
    RST = 1'b1;
    #1;
    n_cmp++;
    if (bus.PDEPTH !== 9'd100 || bus.RESTART_CNT !== 8'd0
        || bus.READY !== 1'b0 || bus.BUSY !== 1'b1
        || bus.RESTART !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst: pd=%0d cnt=%0d rdy=%b busy=%b",
               bus.PDEPTH, bus.RESTART_CNT,
               bus.READY, bus.BUSY);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    mode = 0;
    wait_ready(ok);
    n_cmp++;
    if (!ok || n_pulse != p0 || bus.RESTART_CNT !== 8'd0
        || bus.PDEPTH !== 9'd100) begin
      n_bad++;
      $display("FAIL mid_rst_run: ok=%b pulses=%0d cnt=%0d pd=%0d",
               ok, n_pulse - p0, bus.RESTART_CNT, bus.PDEPTH);
    end
  endtask

  initial begin
    bus.CFG_WR = 1'b0;
    bus.CFG_DEPTH = '0;
    bus.FORCE_RESTART = 1'b0;
    bus.CLR_ERR = 1'b0;
    test_reset();
    test_write();
    test_range();
    test_busy_and_combo();
    test_timeout();
    test_re_loss();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
